// File: rtl/rsh_pkg.sv
// Shared types for the sequential shift unit rsh_seq and its step cell.
package rsh_pkg;

  typedef enum logic [1:0] {
    LSR = 2'b00,
    ASR = 2'b01,
    LSL = 2'b10,
    ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } rsh_state_t;

endpackage

// File: rtl/rsh_step.sv
// Single-bit-position shift step, purely combinational.
// Rotate-right case exists only when RSH_ROTATE_EN is defined; otherwise mode 11 acts as LSR.
module rsh_step
  import rsh_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] value,
  input  shift_mode_t  mode,
  output logic [W-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
    result = {1'b0, value[W-1:1]};
    case (mode)
      ASR:     result = {value[W-1], value[W-1:1]};
      LSL:     result = {value[W-2:0], 1'b0};
`ifdef RSH_ROTATE_EN
      ROR:     result = {value[0], value[W-1:1]};
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/rsh_seq.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
// Define RSH_ROTATE_EN to make mode 11 a rotate right (else it behaves as LSR).
module rsh_seq
  import rsh_pkg::*;
#(
  parameter  int W  = 7,
  localparam int AW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy
);

  rsh_state_t    state, state_next;
  logic [W-1:0]  work;
  logic [W-1:0]  step_out;
  logic [AW-1:0] cnt;
  shift_mode_t   mode;

  rsh_step #(.W(W)) u_step (
    .value  (work),
    .mode   (mode),
    .result (step_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      mode  <= LSR;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          work <= in_data;
          cnt  <= in_amt;
          mode <= shift_mode_t'(in_mode);
        end
        SHIFT: begin
          work <= step_out;
          cnt  <= cnt - AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = (in_amt != '0) ? SHIFT : DONE;
      end
      // Counter is never zero here: amt 0 bypasses SHIFT entirely.
      SHIFT: if (cnt == AW'(1)) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        out_data  = work;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rsh_seq.sv
// Directed and randomised bench for rsh_seq (W=7); expectations follow RSH_ROTATE_EN.
module tb_rsh_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  rsh_seq #(.W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Independent reference built from native shift operators.
  function automatic logic [6:0] ref_shift(input logic [6:0] d, input logic [2:0] a, input logic [1:0] m);
    logic signed [6:0] s;
    logic [13:0]       dd;
    s  = d;
    dd = {d, d};
    case (m)
      2'b01:   return s >>> a;
      2'b10:   return d << a;
`ifdef RSH_ROTATE_EN
      2'b11:   return dd[6:0] >> 0 == 0 ? 7'(dd >> (a % 7)) : 7'(dd >> (a % 7));
`endif
      default: return d >> a;
    endcase
  endfunction

  // Present a request for one cycle; caller is at a negedge with the unit idle.
  task automatic send(input logic [6:0] d, input logic [2:0] a, input logic [1:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge (=1) until out_valid is seen; bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 7'h7f; in_amt = 3'd3; in_mode = 2'b00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 7'd0) begin errors++; $display("FAIL reset_out_data got=%b exp=0000000", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_lsr();
    int lat;
    int ready_high;
    ready_high = 0;
    send(7'b1011010, 3'd3, 2'b00);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) ready_high++;
      @(negedge clk);
      lat++;
    end
    checks++; if (ready_high != 0) begin errors++; $display("FAIL lsr_in_ready_low high_cycles=%0d exp=0", ready_high); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lsr_in_ready_done got=%b exp=0", in_ready); end
    checks++; if (lat != 4) begin errors++; $display("FAIL lsr_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 7'b0001011) begin errors++; $display("FAIL lsr_data got=%b exp=0001011", out_data); end
    take_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL lsr_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_asr_lsl();
    logic [6:0] d [3] = '{7'b1000000, 7'b0000111, 7'b1000000};
    logic [2:0] a [3] = '{3'd2, 3'd5, 3'd7};
    logic [1:0] m [3] = '{2'b01, 2'b10, 2'b01};
    logic [6:0] e [3] = '{7'b1110000, 7'b1100000, 7'b1111111};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send(d[i], a[i], m[i]);
      wait_valid(lat);
      checks++; if (out_data !== e[i]) begin errors++; $display("FAIL asr_lsl_data[%0d] got=%b exp=%b", i, out_data, e[i]); end
      checks++; if (lat != int'(a[i]) + 1) begin errors++; $display("FAIL asr_lsl_latency[%0d] got=%0d exp=%0d", i, lat, int'(a[i]) + 1); end
      take_result();
    end
  endtask

  task automatic test_ror();
    logic [2:0] a [2] = '{3'd1, 3'd7};
`ifdef RSH_ROTATE_EN
    logic [6:0] e [2] = '{7'b1000000, 7'b0000001};
`else
    logic [6:0] e [2] = '{7'b0000000, 7'b0000000};
`endif
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(7'b0000001, a[i], 2'b11);
      wait_valid(lat);
      checks++; if (out_data !== e[i]) begin errors++; $display("FAIL ror_data[%0d] got=%b exp=%b", i, out_data, e[i]); end
      checks++; if (lat != int'(a[i]) + 1) begin errors++; $display("FAIL ror_latency[%0d] got=%0d exp=%0d", i, lat, int'(a[i]) + 1); end
      take_result();
    end
  endtask

  task automatic test_amt0_backpressure();
    int lat;
    send(7'b0101010, 3'd0, 2'b00);
    wait_valid(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL amt0_latency got=%0d exp=1", lat); end
    // Offer a competing request while the result is stalled.
    in_valid = 1'b1; in_data = 7'b0000011; in_amt = 3'd1; in_mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 7'b0101010 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall[%0d] out_valid=%b out_data=%b in_ready=%b exp=1/0101010/0", i, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    checks++; if (out_data !== 7'b0101010) begin errors++; $display("FAIL stall_final got=%b exp=0101010", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_handshake in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_req_accept busy=%b exp=1", busy); end
    wait_valid(lat);
    checks++; if (out_data !== 7'b0000110 || lat != 2) begin
      errors++; $display("FAIL held_req_result got=%b lat=%0d exp=0000110 lat=2", out_data, lat);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    send(7'b1111111, 3'd6, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 7'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid in_ready=%b out_valid=%b out_data=%b busy=%b exp=1/0/0000000/0", in_ready, out_valid, out_data, busy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_mid_no_output valid_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] d, exp_d;
    logic [2:0] a;
    logic [1:0] m;
    int lat, stall;
    for (int n = 0; n < 10; n++) begin
      d = 7'($urandom_range(0, 127));
      a = 3'($urandom_range(0, 7));
      m = 2'($urandom_range(0, 3));
      exp_d = ref_shift(d, a, m);
      send(d, a, m);
      wait_valid(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++; $display("FAIL b2b[%0d] d=%b a=%0d m=%b got=%b valid=%b exp=%b", n, d, a, m, out_data, out_valid, exp_d);
      end
      take_result();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup[%0d] out_valid=%b exp=0", n, out_valid); end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_lsr();
    test_asr_lsl();
    test_ror();
    test_amt0_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsh_seq.md
# rsh_seq

Parametrised, multi-cycle shift unit; successor to the 7-bit combinational right shifter. It accepts an operand, shift amount and mode through a valid/ready handshake. It shifts one bit position per clock under a small state machine, then holds the result behind an output valid/ready handshake. It sits between the datapath register stage and result writeback wherever a variable shift is needed and single-cycle barrel-shifter area is not justified.

## Interface
- `W`, 7: operand width in bits (W ≥ 2).
- `AW`, localparam = $clog2(W+1): shift-amount width; amounts 0..2^AW−1 are legal.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request.
- `in_data` input W: operand.
- `in_amt` input AW: shift amount.
- `in_mode` input 2: 00 LSR, 01 ASR, 10 LSL, 11 ROR.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `out_data` output W: result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_data` into the work register, `in_amt` into the down-counter and `in_mode` into the mode register.
  - Go to SHIFT if `in_amt` ≠ 0, else to DONE.
- **SHIFT**
  - Each cycle, apply one step to the work register and decrement the counter.
  - Step per mode:
    - LSR: {0, r[W−1:1]}.
    - ASR: {r[W−1], r[W−1:1]}.
    - LSL: {r[W−2:0], 0}.
    - ROR: {r[0], r[W−1:1]}.
  - When the counter reaches 1 on a step cycle, go to DONE after that step.
- **DONE**
  - `out_valid`=1 and `out_data`=work register.
  - On `out_ready`, go to IDLE.
  - `out_data` and `out_valid` stay stable until the handshake completes.
- Amounts ≥ W are legal and iterate fully:
  - LSR and LSL give 0.
  - ASR gives all sign bits.
  - ROR gives a rotation by amt mod W.
- `in_valid` outside IDLE is ignored; no request is queued. The upstream holds its request until `in_ready` is high.
- `out_ready` outside DONE has no effect.
- `out_data` is 0 outside DONE.

## Timing
- Reset (synchronous, highest priority, valid in any state, including mid-SHIFT):
  - State returns to IDLE.
  - Work register, counter and mode clear to 0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
  - An in-flight operation is discarded with no output.
- Latency: `out_valid` rises amt+1 cycles after the accepting edge. For amt=0 it rises the cycle after acceptance.
- Throughput: one operation per amt+2 cycles minimum (the DONE→IDLE cycle is not overlapped).
- All outputs are registered-state decodes; there is no combinational path from inputs to outputs.

## Configuration
- `RSH_ROTATE_EN` defined: mode 11 is rotate right, as described above.
- `RSH_ROTATE_EN` not defined:
  - Rotate logic is omitted.
  - Mode 11 behaves exactly as LSR, with identical latency.
  - All other behaviour is unchanged.

## Structure
- Shared package `rsh_pkg` holds:
  - the `shift_mode_t` enum (LSR, ASR, LSL, ROR with the encodings above);
  - the `rsh_state_t` enum (IDLE, SHIFT, DONE).
- One sub-module, `rsh_step`: a combinational single-bit step (W-bit value and mode in, W-bit value out), parametrised by W.
  - The rotate case inside `rsh_step` is guarded by the same `RSH_ROTATE_EN` macro.

## Test plan
- LSR: data 7'b1011010, amt 3, mode 00 → `out_data` 7'b0001011. `out_valid` rises exactly 4 cycles after acceptance; `in_ready` is low for the whole duration.
- ASR and LSL:
  - data 7'b1000000, amt 2, mode 01 → 7'b1110000.
  - data 7'b0000111, amt 5, mode 10 → 7'b1100000.
  - data 7'b1000000, amt 7, mode 01 → 7'b1111111.
- ROR (with `RSH_ROTATE_EN`):
  - data 7'b0000001, amt 1 → 7'b1000000.
  - data 7'b0000001, amt 7 → 7'b0000001.
  - Without the macro, data 7'b0000001, amt 1, mode 11 → 7'b0000000.
- Amt 0 and backpressure:
  - data 7'b0101010, amt 0 → `out_valid` on the next cycle with data unchanged.
  - Hold `out_ready`=0 for 3 cycles → data and valid stay stable.
  - A new `in_valid` during that time is not accepted; it is accepted on the first cycle after the output handshake completes.
- Reset mid-operation: data 7'b1111111, amt 6; assert `reset` on the 3rd SHIFT cycle → the next cycle shows IDLE, `out_valid`=0, `out_data`=0, `in_ready`=1, and no result is ever emitted.
- Back-to-back: 10 random requests with random amt and mode, with random `out_ready` stalls, checked against a reference model (bit-exact results, in order, no drops or duplicates).
